spi_byte_framer: RTL and testbench
==================================

// Module: spi_byte_framer
// PURPOSE
//  Byte-level controller for the 8-bit SPI slave shift register (MSB first, CPHA=1, CPOL=0).
//  Frames the serial stream with cs_n and counts sclk falling edges.
//  Reloads the shift register with the next TX byte through its parallel-load port.
//  Captures each completed RX byte into a small FIFO with a valid/ready handshake.
// PARAMETERS
//  RX_DEPTH  2      RX FIFO entries (power of 2, >=2)
//  FILL_BYTE 8'hFF  byte shifted out when no TX byte is held at load time
//  CNT_W     8      width of byte_cnt (wraps modulo 2^CNT_W)
// PORTS
//  writeClk     in   1       system clock; all logic on posedge
//  reset        in   1       reset, synchronous, active-high
//  cs_n         in   1       SPI chip select, active low, already synchronous to writeClk
//  sclk         in   1       SPI clock, already synchronous to writeClk (same net fed to shift reg)
//  sr_pOut      in   8       shift register parallel out
//  sr_pIn       out  8       shift register parallel load data
//  sr_writeP    out  1       shift register parallel load strobe, 1 cycle
//  sr_reset_n   out  1       shift register reset, = ~reset
//  tx_data      in   8       next byte to transmit
//  tx_valid     in   1       tx_data valid
//  tx_ready     out  1       1-entry TX holding register empty
//  rx_data      out  8       head of RX FIFO
//  rx_valid     out  1       RX FIFO not empty
//  rx_ready     in   1       consumer pops head when rx_valid&rx_ready
//  rx_overflow  out  1       1-cycle pulse: completed byte dropped, FIFO full
//  tx_underrun  out  1       1-cycle pulse: FILL_BYTE loaded
//  frame_abort  out  1       1-cycle pulse: cs_n rose with 1..7 bits counted
//  byte_cnt     out  CNT_W   bytes completed in current frame
// BEHAVIOUR
//  Reset: state=IDLE, armed=0, all pulses 0, sr_writeP=0, sr_pIn=0, FIFO/hold empty, byte_cnt=0.
//  sclk_q = sclk delayed one writeClk cycle; fall = sclk_q & ~sclk.
//  armed: set when cs_n==1 in IDLE, cleared by reset. Blocks a frame caught mid-transfer after reset.
//  FSM:
//  - IDLE -> LOAD when armed & cs_n==0; byte_cnt<=0.
//  - LOAD: one cycle, sr_writeP=1.
//    - Hold full: sr_pIn=hold, hold cleared.
//    - Hold empty: sr_pIn=FILL_BYTE, tx_underrun=1.
//    - bit_cnt<=0; -> SHIFT.
//  - SHIFT: bit_cnt++ on fall. On the fall with bit_cnt==7 -> CAPTURE.
//  - CAPTURE: one cycle. Shift reg updated on the 8th fall, so sr_pOut is valid here.
//    - Push sr_pOut to RX FIFO; byte_cnt++ (wraps).
//    - Push when full: byte dropped, rx_overflow=1.
//    - Then -> LOAD if cs_n==0, else IDLE.
//  - Any state except IDLE, cs_n==1 -> IDLE next cycle, overriding other transitions.
//    frame_abort=1 iff in SHIFT with bit_cnt in 1..7; partial byte discarded.
//  Load timing: sclk is low after the 8th fall, so the load precedes the next rising edge.
//    sclk high/low phases must each be >=3 writeClk cycles.
//  TX hold: accepts tx_data when tx_valid&tx_ready. Accept and LOAD in the same cycle:
//    LOAD uses the prior hold content (FILL if empty); new byte waits for next LOAD (no bypass).
//  RX FIFO: push and pop in one cycle while full -> both succeed, no overflow.
//    Pop while empty is ignored.
//  Pulses are never asserted in consecutive cycles except through distinct events.
// TESTING
//  1 cs_n high 2 cycles, tx 8'hA5 held, then cs_n low; master sends 8'h3C at sclk=8 clk period
//    -> MISO bits 1,0,1,0,0,1,0,1; rx_data=8'h3C; rx_valid=1; byte_cnt=1.
//  2 No tx byte held -> tx_underrun pulse in LOAD; MISO=8'hFF; rx byte still captured.
//  3 RX_DEPTH=2, rx_ready=0, 3 bytes sent (11,22,33)
//    -> third byte gives rx_overflow pulse; FIFO pops 8'h11, 8'h22.
//  4 cs_n rises after 4 falls -> frame_abort=1 one cycle; nothing pushed; state IDLE.
//  5 reset asserted mid-byte with cs_n low -> outputs at reset values.
//    No LOAD until cs_n high then low again.
//  6 FIFO full, rx_ready=1 in the CAPTURE cycle -> no overflow; 2 entries remain.

Source files
------------

// File: rtl/spi_byte_framer.sv
// Byte framer for an 8-bit SPI slave shift register (MSB first, CPOL=0, CPHA=1).
// Frames on cs_n, counts sclk falls, reloads TX bytes and queues RX bytes.
//
// state   | meaning
// IDLE    | no frame; arms once cs_n is seen high
// LOAD    | parallel-load strobe to shift register (hold byte or fill)
// SHIFT   | counting sclk falls of the current byte
// CAPTURE | shift register holds a full RX byte; push it to the FIFO
module spi_byte_framer #(
   parameter int         RX_DEPTH  = 2,
   parameter logic [7:0] FILL_BYTE = 8'hFF,
   parameter int         CNT_W     = 8
) (
   input  logic             writeClk,
   input  logic             reset,
   input  logic             cs_n,
   input  logic             sclk,
   input  logic [7:0]       sr_pOut,
   output logic [7:0]       sr_pIn,
   output logic             sr_writeP,
   output logic             sr_reset_n,
   input  logic [7:0]       tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic             rx_overflow,
   output logic             tx_underrun,
   output logic             frame_abort,
   output logic [CNT_W-1:0] byte_cnt
);
   localparam int PTR_W = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, CAPTURE} state_t;

   state_t           state;
   logic             sclkQ;
   logic             armed;
   logic             holdFull;
   logic [7:0]       holdData;
   logic [2:0]       bitCnt;
   logic [7:0]       rxMem [RX_DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic [PTR_W:0]   rxCount;
   logic             fall;
   logic             rxFull;
   logic             pop;
   logic             pushOk;
   logic             txAccept;
   logic             goLoad;

   assign fall       = sclkQ & ~sclk;
   assign sr_reset_n = ~reset;
   assign tx_ready   = ~holdFull;
   assign txAccept   = tx_valid & ~holdFull;
   assign rx_valid   = (rxCount != '0);
   assign rxFull     = (rxCount == (PTR_W+1)'(RX_DEPTH));
   assign rx_data    = rxMem[rdPtr];
   assign pop        = rx_valid & rx_ready;
   // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
   assign pushOk     = (state == CAPTURE) & (~rxFull | pop);
   assign goLoad     = ~cs_n & (((state == IDLE) & armed) | (state == CAPTURE));

   always_ff @(posedge writeClk) begin
      if (reset) begin
         state       <= IDLE;
         sclkQ       <= 1'b0;
         armed       <= 1'b0;
         holdFull    <= 1'b0;
         holdData    <= 8'h00;
         bitCnt      <= 3'd0;
         byte_cnt    <= '0;
         sr_pIn      <= 8'h00;
         sr_writeP   <= 1'b0;
         tx_underrun <= 1'b0;
         rx_overflow <= 1'b0;
         frame_abort <= 1'b0;
      end else begin
         sclkQ       <= sclk;
         sr_writeP   <= 1'b0;
         tx_underrun <= 1'b0;
         rx_overflow <= 1'b0;
         frame_abort <= 1'b0;

         if (state == IDLE && cs_n) armed <= 1'b1;

         if (txAccept) begin
            holdFull <= 1'b1;
            holdData <= tx_data;
         end

         case (state)
            IDLE: begin
               if (armed && !cs_n) begin
                  state    <= LOAD;
                  byte_cnt <= '0;
               end
            end
            LOAD: begin
               bitCnt <= 3'd0;
               state  <= cs_n ? IDLE : SHIFT;
            end
            SHIFT: begin
               if (cs_n) begin
                  state       <= IDLE;
                  frame_abort <= (bitCnt != 3'd0);
               end else if (fall) begin
                  bitCnt <= bitCnt + 3'd1;
                  if (bitCnt == 3'd7) state <= CAPTURE;
               end
            end
            CAPTURE: begin
               byte_cnt    <= byte_cnt + 1'b1;
               rx_overflow <= rxFull & ~pop;
               state       <= cs_n ? IDLE : LOAD;
            end
            default: state <= IDLE;
         endcase

         // load strobe is registered so it is high exactly during the LOAD cycle;
         // a byte accepted now is not bypassed and waits for the next load
         if (goLoad) begin
            sr_writeP <= 1'b1;
            if (holdFull) begin
               sr_pIn   <= holdData;
               holdFull <= 1'b0;
            end else begin
               sr_pIn      <= FILL_BYTE;
               tx_underrun <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge writeClk) begin
      if (reset) begin
         wrPtr   <= '0;
         rdPtr   <= '0;
         rxCount <= '0;
      end else begin
         if (pushOk) begin
            rxMem[wrPtr] <= sr_pOut;
            wrPtr        <= wrPtr + 1'b1;
         end
         if (pop) rdPtr <= rdPtr + 1'b1;
         if (pushOk && !pop)      rxCount <= rxCount + 1'b1;
         else if (!pushOk && pop) rxCount <= rxCount - 1'b1;
      end
   end
endmodule

// File: tb/tb_spi_byte_framer.sv
// Testbench for spi_byte_framer: models the external shift register and an SPI master,
// and checks MISO bytes, RX FIFO contents and status pulses against a frame-level model.
module tb_spi_byte_framer;
   localparam logic [7:0] FILL  = 8'hFF;
   localparam int         DEPTH = 2;

   logic       writeClk = 1'b0;
   logic       reset    = 1'b1;
   logic       cs_n     = 1'b1;
   logic       sclk     = 1'b0;
   logic [7:0] sr_pOut;
   logic [7:0] sr_pIn;
   logic       sr_writeP;
   logic       sr_reset_n;
   logic [7:0] tx_data  = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b0;
   logic       rx_overflow;
   logic       tx_underrun;
   logic       frame_abort;
   logic [7:0] byte_cnt;

   int nPass   = 0;
   int nChecks = 0;

   spi_byte_framer #(.RX_DEPTH(DEPTH), .FILL_BYTE(FILL), .CNT_W(8)) dut (
      .writeClk(writeClk), .reset(reset), .cs_n(cs_n), .sclk(sclk),
      .sr_pOut(sr_pOut), .sr_pIn(sr_pIn), .sr_writeP(sr_writeP), .sr_reset_n(sr_reset_n),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .rx_overflow(rx_overflow), .tx_underrun(tx_underrun), .frame_abort(frame_abort),
      .byte_cnt(byte_cnt)
   );

   always #5 writeClk = ~writeClk;

   // external shift register: parallel load, shift on sclk fall, MISO = bit 7
   logic [7:0] shReg   = 8'h00;
   logic [7:0] misoAcc = 8'h00;
   logic       mosi    = 1'b0;
   logic       sclkD   = 1'b0;
   always @(posedge writeClk) begin
      sclkD <= sclk;
      if (!sr_reset_n) shReg <= 8'h00;
      else if (sr_writeP) shReg <= sr_pIn;
      else if (sclkD && !sclk) begin
         misoAcc <= {misoAcc[6:0], shReg[7]};
         shReg   <= {shReg[6:0], mosi};
      end
   end
   assign sr_pOut = shReg;

   int         nUnder = 0, nOver = 0, nAbort = 0, nLoad = 0;
   bit         txAccepted = 1'b0;
   logic [7:0] gotRx[$];

   int         fN;
   logic [7:0] fMosi [9];
   bit         fOffer [9];
   logic [7:0] fTx [9];
   bit         fReady;
   int         fCapPop;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) nPass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // observe the cycle with inputs final for the coming edge, then advance to the negedge
   task automatic step();
      if (tx_underrun) nUnder++;
      if (rx_overflow) nOver++;
      if (frame_abort) nAbort++;
      if (sr_writeP) nLoad++;
      if (tx_valid && tx_ready) txAccepted = 1'b1;
      if (rx_valid && rx_ready) gotRx.push_back(rx_data);
      @(negedge writeClk);
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic sendByte(input logic [7:0] mb, input bit offer, input logic [7:0] txb,
                           input bit capPop);
      for (int i = 7; i >= 0; i--) begin
         sclk = 1'b1;
         mosi = mb[i];
         if (i == 7 && offer) begin
            tx_valid   = 1'b1;
            tx_data    = txb;
            txAccepted = 1'b0;
         end
         step();
         tx_valid = 1'b0;
         steps(3);
         sclk = 1'b0;
         if (i == 0 && capPop) begin
            step();
            rx_ready = 1'b1;
            step();
            rx_ready = 1'b0;
            steps(2);
         end else begin
            steps(4);
         end
      end
      if (offer) chk("txAccept", txAccepted, 1);
   endtask

   task automatic runFrame(input string nm);
      int         u0, o0, a0, expU, expO, occ;
      logic [7:0] expQ[$];
      rx_ready = fReady;
      gotRx.delete();
      u0 = nUnder; o0 = nOver; a0 = nAbort;
      if (fOffer[0]) begin
         tx_valid = 1'b1; tx_data = fTx[0]; txAccepted = 1'b0;
         step();
         tx_valid = 1'b0;
         chk({nm, "/tx0"}, txAccepted, 1);
      end
      step();
      cs_n = 1'b0;
      steps(4);
      // frame-level model: one load per byte plus a trailing load after the last byte
      expU = 1; expO = 0; occ = 0;
      for (int b = 0; b < fN; b++) begin
         if (!fOffer[b]) expU++;
         if (b == fCapPop && occ > 0) occ--;
         if (occ < DEPTH) begin expQ.push_back(fMosi[b]); occ++; end
         else expO++;
         if (fReady) occ = 0;
         sendByte(fMosi[b], (b + 1 < fN) && fOffer[b + 1], fTx[b + 1], b == fCapPop);
         chk({nm, "/miso"}, misoAcc, fOffer[b] ? fTx[b] : FILL);
         chk({nm, "/byteCnt"}, byte_cnt, b + 1);
      end
      cs_n = 1'b1;
      steps(3);
      chk({nm, "/underrun"}, nUnder - u0, expU);
      chk({nm, "/overflow"}, nOver - o0, expO);
      chk({nm, "/abort"}, nAbort - a0, 0);
      chk({nm, "/byteCntEnd"}, byte_cnt, fN);
      if (!fReady) begin
         chk({nm, "/rxValid"}, rx_valid, 1);
         chk({nm, "/rxHead"}, rx_data, (fCapPop >= 0) ? expQ[1] : expQ[0]);
      end
      rx_ready = 1'b1;
      steps(6);
      rx_ready = 1'b0;
      step();
      chk({nm, "/drained"}, rx_valid, 0);
      chk({nm, "/rxCount"}, gotRx.size(), expQ.size());
      for (int i = 0; i < expQ.size() && i < gotRx.size(); i++)
         chk({nm, "/rxByte"}, gotRx[i], expQ[i]);
   endtask

   task automatic clearFrame();
      for (int i = 0; i < 9; i++) begin
         fMosi[i] = 8'h00; fOffer[i] = 1'b0; fTx[i] = 8'h00;
      end
      fReady = 1'b0; fCapPop = -1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, l0;
      steps(3);
      chk("rst/writeP", sr_writeP, 0);
      chk("rst/pIn", sr_pIn, 0);
      chk("rst/txReady", tx_ready, 1);
      chk("rst/rxValid", rx_valid, 0);
      chk("rst/byteCnt", byte_cnt, 0);
      chk("rst/pulses", {tx_underrun, rx_overflow, frame_abort}, 0);
      chk("rst/srReset", sr_reset_n, 0);
      reset = 1'b0;
      steps(2);
      chk("run/srReset", sr_reset_n, 1);

      // basic byte: A5 out, 3C in
      clearFrame();
      fN = 1; fMosi[0] = 8'h3C; fOffer[0] = 1'b1; fTx[0] = 8'hA5;
      runFrame("t1");

      // nothing held: fill byte out
      clearFrame();
      fN = 1; fMosi[0] = 8'h5A;
      runFrame("t2");

      // FIFO full, third byte dropped
      clearFrame();
      fN = 3; fMosi[0] = 8'h11; fMosi[1] = 8'h22; fMosi[2] = 8'h33;
      runFrame("t3");

      // full FIFO with a pop in the capture cycle
      clearFrame();
      fN = 3; fMosi[0] = 8'h44; fMosi[1] = 8'h55; fMosi[2] = 8'h66; fCapPop = 2;
      fOffer[1] = 1'b1; fTx[1] = 8'hC3;
      runFrame("t6");

      // abort after 4 falls
      a0 = nAbort;
      cs_n = 1'b0;
      steps(4);
      for (int i = 0; i < 4; i++) begin
         sclk = 1'b1; steps(4);
         sclk = 1'b0; steps(4);
      end
      cs_n = 1'b1;
      steps(3);
      chk("t4/abort", nAbort - a0, 1);
      chk("t4/rxValid", rx_valid, 0);
      chk("t4/byteCnt", byte_cnt, 0);

      // reset mid-byte with cs_n held low, TX hold full
      cs_n = 1'b0;
      steps(4);
      tx_valid = 1'b1; tx_data = 8'h96;
      for (int i = 0; i < 3; i++) begin
         sclk = 1'b1; step(); tx_valid = 1'b0; steps(3);
         sclk = 1'b0; steps(4);
      end
      sclk = 1'b1;
      steps(2);
      chk("t5/holdFull", tx_ready, 0);
      reset = 1'b1;
      steps(2);
      sclk = 1'b0;
      reset = 1'b0;
      chk("t5/pIn", sr_pIn, 0);
      chk("t5/writeP", sr_writeP, 0);
      chk("t5/txReady", tx_ready, 1);
      chk("t5/rxValid", rx_valid, 0);
      chk("t5/byteCnt", byte_cnt, 0);
      l0 = nLoad; a0 = nAbort;
      steps(12);
      chk("t5/noLoad", nLoad - l0, 0);
      cs_n = 1'b1;
      steps(2);
      cs_n = 1'b0;
      steps(4);
      chk("t5/load", nLoad - l0, 1);
      cs_n = 1'b1;
      steps(3);
      chk("t5/abort", nAbort - a0, 0);

      // randomized frames
      for (int k = 0; k < 6; k++) begin
         clearFrame();
         fN = int'($urandom_range(1, 4));
         for (int b = 0; b < fN; b++) begin
            fMosi[b]  = 8'($urandom);
            fOffer[b] = 1'($urandom_range(0, 1));
            fTx[b]    = 8'($urandom);
         end
         fReady  = 1'($urandom_range(0, 1));
         fCapPop = (!fReady && fN >= 3 && $urandom_range(0, 1) == 1) ? fN - 1 : -1;
         runFrame("rnd");
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end
endmodule
